// File: rtl/fa_pipe_adder_if.sv
// Handshake and data bundle for fa_pipe_adder.
// Defining FA_PIPE_OVF_EN adds the OVF result bit alongside SUM/Cout.
interface fa_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
`ifdef FA_PIPE_OVF_EN
    logic             OVF;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, SUM, Cout, OVF
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, SUM, Cout, OVF
    );
`else
    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, SUM, Cout
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, SUM, Cout
    );
`endif
endinterface

// File: rtl/fa_pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES segments, one per clock.
// Optional FA_PIPE_OVF_EN registers a signed-overflow flag with the final stage.
module fa_pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input logic           clk,
    input logic           rst,
    fa_pipe_adder_if.slave bus
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("fa_pipe_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];

    logic             v_d [STAGES];
    logic             c_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [SEG:0]     part [STAGES];

    logic adv;

    assign adv = !v_q[LAST] || bus.out_ready;

    // a_d/b_d[k] are the operands entering stage k; each stage adds only its own slice.
    always_comb begin
        v_d[0]  = bus.in_valid;
        a_d[0]  = bus.A;
        b_d[0]  = bus.B;
        part[0] = {1'b0, bus.A[SEG-1:0]} + {1'b0, bus.B[SEG-1:0]} + (SEG+1)'(bus.Cin);
        c_d[0]  = part[0][SEG];
        s_d[0]  = '0;
        s_d[0][SEG-1:0] = part[0][SEG-1:0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_d[k]  = v_q[k-1];
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            part[k] = {1'b0, a_q[k-1][k*SEG +: SEG]}
                    + {1'b0, b_q[k-1][k*SEG +: SEG]}
                    + (SEG+1)'(c_q[k-1]);
            c_d[k]  = part[k][SEG];
            s_d[k]  = s_q[k-1];
            s_d[k][k*SEG +: SEG] = part[k][SEG-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

`ifdef FA_PIPE_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered as a^b^sum at that bit.
    always_comb begin
        ovf_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.OVF = ovf_q;
`endif

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[LAST];
    assign bus.SUM       = s_q[LAST];
    assign bus.Cout      = c_q[LAST];

endmodule

// File: tb/tb_fa_pipe_adder.sv
// Self-checking bench for fa_pipe_adder (16b/4-stage scoreboarded, plus an 8b/1-stage instance).
// Build with FA_PIPE_OVF_EN defined to also exercise the OVF output.
module tb_fa_pipe_adder;
    localparam int unsigned W = 16;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fa_pipe_adder_if #(.WIDTH(W)) bus ();
    fa_pipe_adder_if #(.WIDTH(8)) bus8 ();

    fa_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fa_pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on acceptance, pop and compare on consumption.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() != 0) e = sb.pop_front();
                else                e = 'x;
                chk("sb_sum_cout", {15'b0, bus.Cout, bus.SUM}, {15'b0, e.cout, e.sum});
`ifdef FA_PIPE_OVF_EN
                chk("sb_ovf", {31'b0, bus.OVF}, {31'b0, e.ovf});
`endif
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.A, bus.B, bus.Cin));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] snap;
        bit         drained;

        rst = 1'b1;
        bus.in_valid = 1'b0;  bus.A = '0;  bus.B = '0;  bus.Cin = 1'b0;  bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0; bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_sum",       {16'b0, bus.SUM},       32'd0);
        chk("rst_cout",      {31'b0, bus.Cout},      32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        chk("rst8_out_valid", {31'b0, bus8.out_valid}, 32'd0);
`ifdef FA_PIPE_OVF_EN
        chk("rst_ovf", {31'b0, bus.OVF}, 32'd0);
`endif

        // Carry ripple through all stages, latency exactly STAGES
        @(posedge clk); #1;
        bus.A = 16'hFFFF; bus.B = 16'h0001; bus.Cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lat_not_yet", {31'b0, bus.out_valid}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("lat_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("ripple_sum", {16'b0, bus.SUM}, 32'h0000);
        chk("ripple_cout", {31'b0, bus.Cout}, 32'd1);

        // Back-to-back accepts
        @(posedge clk); #1;
        bus.A = 16'h0001; bus.B = 16'h0002; bus.Cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 16'h8000; bus.B = 16'h8000; bus.Cin = 1'b1;
        @(posedge clk); #1;
        bus.A = 16'h1234; bus.B = 16'h4321; bus.Cin = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("b2b0_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("b2b0", {15'b0, bus.Cout, bus.SUM}, {15'b0, 1'b0, 16'h0003});
        @(posedge clk); @(negedge clk);
        chk("b2b1", {15'b0, bus.Cout, bus.SUM}, {15'b0, 1'b1, 16'h0001});
        @(posedge clk); @(negedge clk);
        chk("b2b2", {15'b0, bus.Cout, bus.SUM}, {15'b0, 1'b0, 16'h5555});
        @(posedge clk); @(negedge clk);
        chk("b2b_done", {31'b0, bus.out_valid}, 32'd0);

        // Backpressure with the pipeline full
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Cin = 1'($urandom); bus.in_valid = 1'b1;
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        snap = {bus.Cout, bus.SUM};
        chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.A = 16'($urandom); bus.B = 16'($urandom);
            @(negedge clk);
            chk("bp_hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_hold_data", {15'b0, bus.Cout, bus.SUM}, {15'b0, snap});
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) drained = 1'b1;
        end
        chk("bp_drained", {31'b0, drained}, 32'd1);

        // Reset mid-flight, with in_valid high on the reset edge
        @(posedge clk); #1;
        bus.A = 16'h0101; bus.B = 16'h0202; bus.Cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 16'h0303; bus.B = 16'h0404;
        @(posedge clk); #1;
        rst = 1'b1; bus.A = 16'h0505;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rstmid_sum", {16'b0, bus.SUM}, 32'd0);
        chk("rstmid_cout", {31'b0, bus.Cout}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rstmid_no_out", {31'b0, bus.out_valid}, 32'd0);
            @(posedge clk); @(negedge clk);
        end

        // Single-stage 8-bit instance
        @(posedge clk); #1;
        bus8.A = 8'hF0; bus8.B = 8'h0F; bus8.Cin = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.A = 8'h12; bus8.B = 8'h34; bus8.Cin = 1'b0;
        @(negedge clk);
        chk("s1_valid", {31'b0, bus8.out_valid}, 32'd1);
        chk("s1_wrap", {23'b0, bus8.Cout, bus8.SUM}, {23'b0, 1'b1, 8'h00});
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("s1_plain", {23'b0, bus8.Cout, bus8.SUM}, {23'b0, 1'b0, 8'h46});
        @(posedge clk); @(negedge clk);
        chk("s1_idle", {31'b0, bus8.out_valid}, 32'd0);

`ifdef FA_PIPE_OVF_EN
        // Signed overflow flag
        @(posedge clk); #1;
        bus.A = 16'h7FFF; bus.B = 16'h0001; bus.Cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 16'hFFFF; bus.B = 16'h0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("ovf0_flag", {31'b0, bus.OVF}, 32'd1);
        chk("ovf0_sum", {15'b0, bus.Cout, bus.SUM}, {15'b0, 1'b0, 16'h8000});
        @(posedge clk); @(negedge clk);
        chk("ovf1_flag", {31'b0, bus.OVF}, 32'd0);
        chk("ovf1_cout", {31'b0, bus.Cout}, 32'd1);
        @(posedge clk);
`endif

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
